// File: rtl/sd_cmd_phys.sv
// SD CMD-line serial engine: shifts out a CRC7-protected 48-bit command and
// collects, checks and hands back the 48-bit response over a req/ack handshake.
module sd_cmd_phys #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_in,
  input  logic [39:0] cmd_in,
  output logic        ack_out,
  output logic        serial_ready,
  output logic        req_out,
  input  logic        ack_in,
  output logic [39:0] cmd_out,
  output logic        timeout_err,
  output logic        crc_err,
  output logic        cmd_pin_out,
  output logic        cmd_pin_oe,
  input  logic        cmd_pin_in
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_SEND, S_WAIT, S_RECV, S_DELIVER, S_GAP
  } state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  state_t        r_state;
  logic [39:0]   r_cmd;
  logic          r_no_resp;
  logic [5:0]    r_bit;
  logic [TW-1:0] r_tmo;
  logic [GW-1:0] r_gap;
  logic [6:0]    r_crc;
  logic [46:0]   r_rx;
  logic          r_ack, r_ready, r_req, r_tmo_err, r_crc_err, r_pin, r_oe;
  logic [39:0]   r_cmd_out;

  logic [5:0] w_nbit;
  logic [5:0] w_didx;
  logic [2:0] w_cidx;
  assign w_nbit = r_bit + 6'd1;
  assign w_didx = 6'd39 - w_nbit;
  assign w_cidx = 3'(6'd46 - w_nbit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_RESET;
      r_cmd     <= '0;
      r_no_resp <= 1'b0;
      r_bit     <= '0;
      r_tmo     <= '0;
      r_gap     <= '0;
      r_crc     <= '0;
      r_rx      <= '0;
      r_ack     <= 1'b0;
      r_ready   <= 1'b0;
      r_req     <= 1'b0;
      r_cmd_out <= '0;
      r_tmo_err <= 1'b0;
      r_crc_err <= 1'b0;
      r_pin     <= 1'b1;
      r_oe      <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_RESET: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        S_IDLE: if (req_in) begin
          // First command bit goes out in the same cycle as the ack pulse.
          r_cmd     <= cmd_in;
          r_no_resp <= (cmd_in[37:32] == 6'd0);
          r_crc     <= crc7_step(7'd0, cmd_in[39]);
          r_pin     <= cmd_in[39];
          r_oe      <= 1'b1;
          r_ack     <= 1'b1;
          r_ready   <= 1'b0;
          r_tmo_err <= 1'b0;
          r_crc_err <= 1'b0;
          r_bit     <= 6'd0;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (r_bit == 6'd47) begin
            r_oe  <= 1'b0;
            r_pin <= 1'b1;
            if (r_no_resp) begin
              r_gap   <= '0;
              r_state <= S_GAP;
            end else begin
              r_tmo   <= '0;
              r_state <= S_WAIT;
            end
          end else begin
            r_bit <= w_nbit;
            if (w_nbit < 6'd40) begin
              r_pin <= r_cmd[w_didx];
              r_crc <= crc7_step(r_crc, r_cmd[w_didx]);
            end else if (w_nbit < 6'd47) begin
              r_pin <= r_crc[w_cidx];
            end else begin
              r_pin <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // A start bit on the expiring cycle still wins over the timeout.
          if (!cmd_pin_in) begin
            r_rx    <= '0;
            r_crc   <= 7'd0;
            r_bit   <= 6'd46;
            r_state <= S_RECV;
          end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            r_tmo_err <= 1'b1;
            r_cmd_out <= '0;
            r_req     <= 1'b1;
            r_state   <= S_DELIVER;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_RECV: begin
          if (r_bit == 6'd0) begin
            // r_rx holds rx[47:1]; the live pin is the end bit.
            r_cmd_out <= r_rx[46:7];
            r_crc_err <= (r_crc != r_rx[6:0]) | ~cmd_pin_in;
            r_req     <= 1'b1;
            r_state   <= S_DELIVER;
          end else begin
            r_rx  <= {r_rx[45:0], cmd_pin_in};
            r_bit <= r_bit - 6'd1;
            if (r_bit >= 6'd8) r_crc <= crc7_step(r_crc, cmd_pin_in);
          end
        end
        S_DELIVER: if (ack_in) begin
          r_req   <= 1'b0;
          r_gap   <= '0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == GW'(GAP_CYCLES - 1)) begin
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign ack_out      = r_ack;
  assign serial_ready = r_ready;
  assign req_out      = r_req;
  assign cmd_out      = r_cmd_out;
  assign timeout_err  = r_tmo_err;
  assign crc_err      = r_crc_err;
  assign cmd_pin_out  = r_pin;
  assign cmd_pin_oe   = r_oe;
endmodule
